pck_injector: RTL and testbench

- Endpoint-side packet injector that drives one router local input port: the `flit_in_all` / `flit_in_we_all` slice of that port, with its `credit_out_all` slice returned.
- Accepts packet descriptors and a payload word stream.
- Builds header/body/tail flits in the router flit format (Fw = 2+V+Fpay).
- Enforces per-VC credit-based flow control against the router input buffers.

---
 rtl/pck_injector_if.sv | 38 +++
 rtl/pck_injector.sv | 170 +++++++++++++++++
 tb/tb_pck_injector.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pck_injector_if.sv
// Endpoint-to-injector bundle: descriptor channel, body-word channel, and the
// router-side flit write / credit return wires.
interface pck_injector_if #(
    parameter int V    = 4,
    parameter int Vw   = 2,
    parameter int Fpay = 32,
    parameter int EAw  = 8,
    parameter int LENw = 5
);
    localparam int Fw = 2 + V + Fpay;

    // valid/ready: a word transfers on the rising clk edge where both are high;
    // the source holds valid and its payload stable until that edge, and ready
    // never waits on valid in this block.
    logic            req_valid;
    logic            req_ready;
    logic [EAw-1:0]  req_dst;
    logic [LENw-1:0] req_len;
    logic [Vw-1:0]   req_vc;

    logic            dat_valid;
    logic            dat_ready;
    logic [Fpay-1:0] dat_in;

    logic [Fw-1:0]   flit_out;
    logic            flit_out_we;
    logic [V-1:0]    credit_in;

    modport master (
        output req_valid, req_dst, req_len, req_vc, dat_valid, dat_in, credit_in,
        input  req_ready, dat_ready, flit_out, flit_out_we
    );

    modport slave (
        input  req_valid, req_dst, req_len, req_vc, dat_valid, dat_in, credit_in,
        output req_ready, dat_ready, flit_out, flit_out_we
    );
endinterface

// File: rtl/pck_injector.sv
// Packet injector: turns descriptors plus a payload word stream into
// header/body/tail flits for one router local port, gated by per-VC credits.
module pck_injector #(
    parameter int V            = 4,
    parameter int Vw           = 2,
    parameter int B            = 4,
    parameter int Fpay         = 32,
    parameter int EAw          = 8,
    parameter int LENw         = 5,
    parameter int MIN_PCK_SIZE = 2,
    parameter int MAX_PCK_SIZE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [EAw-1:0]   current_e_addr,
    pck_injector_if.slave    bus,
    output logic [V-1:0]     credit_avail,
    output logic             busy,
    output logic             credit_err,
    output logic [1:0]       dbg_state
);
    localparam int Fw = 2 + V + Fpay;
    localparam int Cw = $clog2(B) + 1;
    localparam logic [LENw-1:0] LEN_MIN   = LENw'(MIN_PCK_SIZE);
    localparam logic [LENw-1:0] LEN_MAX   = LENw'(MAX_PCK_SIZE);
    localparam logic [LENw-1:0] LEN_ONE   = LENw'(1);
    localparam logic [Cw-1:0]   CRED_FULL = Cw'(B);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [EAw-1:0]       dst_q;
    logic [Vw-1:0]        vc_q;
    logic [LENw-1:0]      len_q;
    logic [LENw-1:0]      left_q, left_n;
    logic [LENw-1:0]      len_clamped;
    logic [V-1:0][Cw-1:0] credit;
    logic                 has_credit;
    logic                 accept;
    logic                 send, send_hdr, send_tail;
    logic [V-1:0]         vc_oh;
    logic [V-1:0]         dec_vec;
    logic [Fpay-1:0]      hdr_pay;
    logic [Fw-1:0]        flit_n;

    always_comb begin
        len_clamped = bus.req_len;
        if (bus.req_len < LEN_MIN)      len_clamped = LEN_MIN;
        else if (bus.req_len > LEN_MAX) len_clamped = LEN_MAX;
    end

    always_comb begin
        vc_oh       = '0;
        vc_oh[vc_q] = 1'b1;
    end

    always_comb begin
        hdr_pay                           = '0;
        hdr_pay[EAw-1:0]                  = dst_q;
        hdr_pay[2*EAw-1:EAw]              = current_e_addr;
        hdr_pay[2*EAw+LENw-1:2*EAw]       = len_q;
    end

    assign has_credit = (credit[vc_q] != '0);
    assign accept     = bus.req_valid && bus.req_ready;

    always_comb begin
        state_n       = state;
        left_n        = left_q;
        bus.req_ready = 1'b0;
        bus.dat_ready = 1'b0;
        send          = 1'b0;
        send_hdr      = 1'b0;
        send_tail     = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_n = HEAD;
            end
            HEAD: begin
                if (has_credit) begin
                    send     = 1'b1;
                    send_hdr = 1'b1;
                    if (len_q == LEN_ONE) begin
                        send_tail = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        left_n  = len_q - LEN_ONE;
                        state_n = BODY;
                    end
                end
            end
            BODY: begin
                // Ready tracks credit only, so a stalled VC back-pressures the word source.
                bus.dat_ready = has_credit;
                if (bus.dat_valid && has_credit) begin
                    send   = 1'b1;
                    left_n = left_q - LEN_ONE;
                    if (left_q == LEN_ONE) begin
                        send_tail = 1'b1;
                        state_n   = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign flit_n  = {send_hdr, send_tail, vc_oh, send_hdr ? hdr_pay : bus.dat_in};
    assign dec_vec = send ? vc_oh : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            dst_q  <= '0;
            vc_q   <= '0;
            len_q  <= '0;
            left_q <= '0;
        end else begin
            state  <= state_n;
            left_q <= left_n;
            if (accept) begin
                dst_q <= bus.req_dst;
                vc_q  <= bus.req_vc;
                len_q <= len_clamped;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.flit_out    <= '0;
            bus.flit_out_we <= 1'b0;
        end else begin
            bus.flit_out_we <= send;
            if (send) bus.flit_out <= flit_n;
        end
    end

    // A return and a send on the same VC cancel; a return into a full counter
    // is a router/endpoint disagreement and is latched until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < V; v++) credit[v] <= CRED_FULL;
            credit_err <= 1'b0;
        end else begin
            for (int v = 0; v < V; v++) begin
                if (bus.credit_in[v] && !dec_vec[v]) begin
                    if (credit[v] == CRED_FULL) credit_err <= 1'b1;
                    else                        credit[v]  <= credit[v] + Cw'(1);
                end else if (dec_vec[v] && !bus.credit_in[v]) begin
                    credit[v] <= credit[v] - Cw'(1);
                end
            end
        end
    end

    always_comb begin
        credit_avail = '0;
        for (int v = 0; v < V; v++) credit_avail[v] = (credit[v] != '0);
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_pck_injector.sv
// Bench for pck_injector: directed cases plus random packets, checked by a
// flit scoreboard and a per-VC credit model.
module tb_pck_injector;
  localparam int V = 4, Vw = 2, B = 4, Fpay = 32, EAw = 8, LENw = 5;
  localparam int MINP = 2, MAXP = 16;
  localparam int Fw = 2 + V + Fpay;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [EAw-1:0] e_addr;
  logic [V-1:0]   credit_avail;
  logic           busy, credit_err;
  logic [1:0]     dbg_state;

  logic [V-1:0]   man_credit, head_pulse, auto_pulse, last_auto;
  bit             auto_credit;

  pck_injector_if bus ();
  assign bus.credit_in = man_credit | head_pulse | auto_pulse;

  pck_injector dut (
    .clk            (clk),
    .reset          (rst),
    .current_e_addr (e_addr),
    .bus            (bus),
    .credit_avail   (credit_avail),
    .busy           (busy),
    .credit_err     (credit_err),
    .dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  // scoreboard and reference state
  logic [Fw-1:0] exp_q[$];
  int            flit_cyc_q[$];
  int            total = 0, bad = 0;
  int            cyc = 0;
  int            acc_cyc;
  int            mcred[V];
  bit            merr;
  logic [V-1:0]  pend;
  logic [Fw-1:0] last_exp, last_hdr;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [Fw-1:0] mk_flit(input bit hd, input bit tl, input int vc,
                                             input logic [Fpay-1:0] pay);
    logic [V-1:0] oh;
    oh = '0;
    oh[vc] = 1'b1;
    return {hd, tl, oh, pay};
  endfunction

  function automatic bit all_full();
    for (int v = 0; v < V; v++) if (mcred[v] != B) return 1'b0;
    return 1'b1;
  endfunction

  // monitor: pops expected flits and tracks credits from sends and returns
  task automatic monitor();
    logic [Fw-1:0] e;
    logic [V-1:0]  decv, avail_m;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int v = 0; v < V; v++) mcred[v] = B;
        merr = 1'b0;
        pend = '0;
        last_exp = '0;
      end else begin
        decv = '0;
        if (bus.flit_out_we) begin
          flit_cyc_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_flit: got %0h expected no flit (cycle %0d)", bus.flit_out, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("flit", bus.flit_out, e);
            last_exp = e;
            decv = e[Fpay+V-1:Fpay];
            if (e[Fw-1]) last_hdr = bus.flit_out;
          end
        end else begin
          chk("flit_hold", bus.flit_out, last_exp);
        end
        for (int v = 0; v < V; v++) begin
          if (pend[v] && !decv[v]) begin
            if (mcred[v] == B) merr = 1'b1;
            else mcred[v] = mcred[v] + 1;
          end else if (decv[v] && !pend[v]) begin
            mcred[v] = mcred[v] - 1;
          end
          avail_m[v] = (mcred[v] > 0);
        end
        chk("credit_avail", credit_avail, avail_m);
        chk("credit_err", credit_err, merr);
        pend = bus.credit_in;
      end
    end
  endtask

  // router stand-in: hands back consumed credits at random times
  initial begin
    auto_pulse = '0;
    last_auto  = '0;
    forever begin
      @(posedge clk);
      #2;
      auto_pulse = '0;
      if (auto_credit && !rst) begin
        for (int v = 0; v < V; v++)
          if ((B - mcred[v] - int'(last_auto[v])) > 0 && $urandom_range(0, 2) == 0)
            auto_pulse[v] = 1'b1;
      end
      last_auto = auto_pulse;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    head_pulse = '0;
  endtask

  task automatic wait_hs(input bit is_dat, output bit ok);
    bit rdy;
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 300) begin
      @(negedge clk);
      rdy = is_dat ? bus.dat_ready : bus.req_ready;
      step();
      if (rdy) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no ready expected ready within 300 cycles", is_dat ? "dat" : "req");
    end
  endtask

  task automatic give_credit(input int v, input int n);
    repeat (n) begin
      man_credit[v] = 1'b1;
      step();
      man_credit[v] = 1'b0;
    end
  endtask

  task automatic send_packet(input logic [EAw-1:0] dst, input logic [LENw-1:0] len, input int vc,
                             input int gap_mode, input bit fixed, input logic [V-1:0] hcred);
    int              clen;
    bit              ok;
    logic [Fpay-1:0] hp;
    logic [Fpay-1:0] w[$];
    clen = int'(len);
    if (clen < MINP) clen = MINP;
    if (clen > MAXP) clen = MAXP;
    hp = '0;
    hp[7:0]   = dst;
    hp[15:8]  = e_addr;
    hp[20:16] = LENw'(clen);
    exp_q.push_back(mk_flit(1'b1, clen == 1, vc, hp));
    for (int i = 1; i < clen; i++) begin
      w.push_back(fixed ? 32'hA + 32'(i - 1) : 32'($urandom()));
      exp_q.push_back(mk_flit(1'b0, i == clen - 1, vc, w[i-1]));
    end
    bus.req_valid = 1'b1;
    bus.req_dst   = dst;
    bus.req_len   = len;
    bus.req_vc    = Vw'(vc);
    wait_hs(1'b0, ok);
    acc_cyc       = cyc;
    head_pulse    = hcred;
    bus.req_valid = 1'b0;
    bus.req_dst   = EAw'($urandom());
    bus.req_len   = LENw'($urandom());
    bus.req_vc    = Vw'($urandom());
    if (!ok) return;
    for (int i = 0; i < w.size(); i++) begin
      if (gap_mode == 1) begin
        repeat ($urandom_range(0, 2)) begin
          bus.dat_valid = 1'b0;
          step();
        end
      end else if (gap_mode == 2 && i > 0) begin
        bus.dat_valid = 1'b0;
        step();
      end
      bus.dat_valid = 1'b1;
      bus.dat_in    = w[i];
      wait_hs(1'b1, ok);
      if (!ok) begin
        bus.dat_valid = 1'b0;
        return;
      end
    end
    bus.dat_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 50000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int              n;
    bit              ok;
    logic [Fpay-1:0] hp;
    bus.req_valid = 1'b0;
    bus.req_dst   = '0;
    bus.req_len   = '0;
    bus.req_vc    = '0;
    bus.dat_valid = 1'b0;
    bus.dat_in    = '0;
    man_credit    = '0;
    head_pulse    = '0;
    auto_credit   = 1'b0;
    e_addr        = 8'h02;
    last_hdr      = '0;
    fork
      monitor();
    join_none

    // clock/reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset values
    chk("reset_flit", bus.flit_out, 0);
    chk("reset_we", bus.flit_out_we, 0);
    chk("reset_avail", credit_avail, 4'hF);
    chk("reset_busy", busy, 0);
    chk("reset_err", credit_err, 0);
    chk("reset_req_ready", bus.req_ready, 1);
    chk("reset_state", dbg_state, 0);

    // basic 3-flit packet, words A and B always valid
    flit_cyc_q.delete();
    send_packet(8'h05, 5'd3, 1, 0, 1'b1, '0);
    step();
    chk("basic_count", flit_cyc_q.size(), 3);
    chk("basic_head_latency", flit_cyc_q[0] - acc_cyc, 1);
    chk("basic_b2b_1", flit_cyc_q[1] - flit_cyc_q[0], 1);
    chk("basic_b2b_2", flit_cyc_q[2] - flit_cyc_q[1], 1);
    chk("basic_header", last_hdr, {2'b10, 4'b0010, 32'h00030205});
    chk("basic_avail", credit_avail, 4'hF);
    give_credit(1, 3);

    // credit stall on vc0 with a 6-flit packet
    flit_cyc_q.delete();
    fork
      send_packet(8'h33, 5'd6, 0, 0, 1'b0, '0);
      begin
        n = 0;
        while (flit_cyc_q.size() < 4 && n < 100) begin
          step();
          n++;
        end
        repeat (3) begin
          @(negedge clk);
          chk("stall_we", bus.flit_out_we, 0);
          chk("stall_dat_ready", bus.dat_ready, 0);
          chk("stall_busy", busy, 1);
        end
        chk("stall_count", flit_cyc_q.size(), 4);
        step();
        give_credit(0, 2);
      end
    join
    chk("stall_busy_done", busy, 0);
    step();
    chk("stall_total", flit_cyc_q.size(), 6);
    give_credit(0, 4);

    // return and send on vc2 in the same cycle, then return into a full vc3
    send_packet(8'h21, 5'd2, 2, 0, 1'b0, '0);
    send_packet(8'h22, 5'd2, 2, 0, 1'b0, 4'b0100);
    step();
    chk("simul_vc2_avail", credit_avail[2], 1);
    give_credit(2, 3);
    step();
    give_credit(3, 1);
    step();
    step();
    chk("full_return_err", credit_err, 1);
    repeat (5) step();
    chk("full_return_sticky", credit_err, 1);
    chk("full_return_avail", credit_avail, 4'hF);

    // reset in the body of an 8-flit packet after 3 flits
    hp = '0;
    hp[7:0]   = 8'h44;
    hp[15:8]  = e_addr;
    hp[20:16] = 5'd8;
    exp_q.push_back(mk_flit(1'b1, 1'b0, 0, hp));
    exp_q.push_back(mk_flit(1'b0, 1'b0, 0, 32'h1111_0001));
    exp_q.push_back(mk_flit(1'b0, 1'b0, 0, 32'h1111_0002));
    bus.req_valid = 1'b1;
    bus.req_dst   = 8'h44;
    bus.req_len   = 5'd8;
    bus.req_vc    = 2'd0;
    wait_hs(1'b0, ok);
    bus.req_valid = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      bus.dat_valid = 1'b1;
      bus.dat_in    = 32'h1111_0000 + 32'(i);
      wait_hs(1'b1, ok);
    end
    bus.dat_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid_seen", exp_q.size(), 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_we", bus.flit_out_we, 0);
    chk("rst_mid_flit", bus.flit_out, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_avail", credit_avail, 4'hF);
    chk("rst_mid_err", credit_err, 0);
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    flit_cyc_q.delete();
    send_packet(8'h07, 5'd3, 3, 0, 1'b0, '0);
    step();
    chk("rst_after_count", flit_cyc_q.size(), 3);

    // length clamps, with credits returned by the router stand-in
    auto_credit = 1'b1;
    flit_cyc_q.delete();
    send_packet(8'h11, 5'd1, 1, 0, 1'b0, '0);
    step();
    chk("len1_count", flit_cyc_q.size(), 2);
    chk("len1_field", last_hdr[20:16], 2);
    flit_cyc_q.delete();
    send_packet(8'h22, 5'd31, 2, 1, 1'b0, '0);
    step();
    chk("len31_count", flit_cyc_q.size(), 16);
    chk("len31_field", last_hdr[20:16], 16);

    // dat_valid toggling 1,0,1,0 with a full credit pool
    n = 0;
    while (!all_full() && n < 300) begin
      step();
      n++;
    end
    chk("pool_refilled", all_full(), 1);
    auto_credit = 1'b0;
    step();
    flit_cyc_q.delete();
    send_packet(8'h5A, 5'd4, 3, 2, 1'b0, '0);
    step();
    chk("toggle_count", flit_cyc_q.size(), 4);
    chk("toggle_gap_1", flit_cyc_q[1] - flit_cyc_q[0], 1);
    chk("toggle_gap_2", flit_cyc_q[2] - flit_cyc_q[1], 2);
    chk("toggle_gap_3", flit_cyc_q[3] - flit_cyc_q[2], 2);

    // random packets
    auto_credit = 1'b1;
    repeat (25) begin
      e_addr = EAw'($urandom());
      send_packet(EAw'($urandom()), LENw'($urandom_range(0, 31)), $urandom_range(0, 3),
                  $urandom_range(0, 1), 1'b0, '0);
      repeat ($urandom_range(0, 2)) step();
    end

    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      step();
      n++;
    end
    step();
    chk("final_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
